// File: rtl/adc_stream_pkg.sv
// rtl/adc_stream_pkg.sv - Shared FSM encoding, sync word default and sample byte split for the ADC UART framer
package adc_stream_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_SYNC_H = 4'd1,
        ST_SYNC_L = 4'd2,
        ST_SEQ_H  = 4'd3,
        ST_SEQ_L  = 4'd4,
        ST_POP    = 4'd5,
        ST_LAT    = 4'd6,
        ST_SMP_H  = 4'd7,
        ST_SMP_L  = 4'd8,
        ST_CKS    = 4'd9,
        ST_END    = 4'd10
    } framer_state_t;

    localparam logic [15:0] SYNC_WORD_DEFAULT = 16'hA55A;

    typedef struct packed {
        logic [7:0] hi;
        logic [7:0] lo;
    } sample_bytes_t;

    // Caller zero-extends the sample to 16 bits, so hi is data[W-1:8] padded with zeros.
    function automatic sample_bytes_t split_sample(input logic [15:0] s);
        sample_bytes_t r;
        r.hi = s[15:8];
        r.lo = s[7:0];
        return r;
    endfunction

endpackage

// File: rtl/adc_uart_framer_if.sv
// rtl/adc_uart_framer_if.sv - Sample FIFO read port and uart_tx byte handshake bundle
interface adc_uart_framer_if #(
    parameter int DATA_WIDTH = 13
);
    logic                  fifo_empty_i;
    logic                  fifo_rd_en_o;
    logic [DATA_WIDTH-1:0] fifo_data_i;
    logic                  tx_start_o;
    logic [7:0]            tx_data_o;
    logic                  tx_done_i;

    modport master (
        input  fifo_empty_i,
        input  fifo_data_i,
        input  tx_done_i,
        output fifo_rd_en_o,
        output tx_start_o,
        output tx_data_o
    );

    modport slave (
        output fifo_empty_i,
        output fifo_data_i,
        output tx_done_i,
        input  fifo_rd_en_o,
        input  tx_start_o,
        input  tx_data_o
    );
endinterface

// File: rtl/uart_byte_issuer.sv
// rtl/uart_byte_issuer.sv - Start pulse, byte hold and done wait for one uart_tx byte
module uart_byte_issuer (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic [7:0] byte_data,
    output logic       done,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic       tx_done
);
    logic       waiting_q;
    logic [7:0] data_q;

    // waiting_q only rises after the start cycle, so a done pulse coincident with start is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            waiting_q <= 1'b0;
            data_q    <= 8'd0;
        end else if (req) begin
            waiting_q <= 1'b1;
            data_q    <= byte_data;
        end else if (waiting_q && tx_done) begin
            waiting_q <= 1'b0;
        end
    end

    assign tx_start = req;
    assign tx_data  = req ? byte_data : data_q;
    assign done     = waiting_q && tx_done;

endmodule

// File: rtl/adc_uart_framer.sv
// rtl/adc_uart_framer.sv - Frames FIFO samples as sync, sequence and sample bytes for uart_tx
// Optional trailing checksum byte: define FRAMER_CHECKSUM_EN
module adc_uart_framer
    import adc_stream_pkg::*;
#(
    parameter int          DATA_WIDTH = 13,
    parameter int          FRAME_LEN  = 64,
    parameter logic [15:0] SYNC_WORD  = SYNC_WORD_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    adc_uart_framer_if.master  bus,
    output logic [15:0]        frame_seq_o,
    output logic               busy_o
);
    localparam int CNT_W = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0] FRAME_LEN_C = CNT_W'(FRAME_LEN);

    framer_state_t         state_q;
    logic                  req_q;
    logic [7:0]            byte_q;
    logic [7:0]            sample_lo_q;
    logic [CNT_W-1:0]      count_q;
    logic [15:0]           frame_seq_q;
    logic                  busy_q;
    logic                  byte_done;
    logic [DATA_WIDTH-1:0] fifo_sample;
    sample_bytes_t         in_bytes;
`ifdef FRAMER_CHECKSUM_EN
    logic [7:0]            cks_q;
`endif

    assign fifo_sample = bus.fifo_data_i;
    assign in_bytes    = split_sample(16'(fifo_sample));

    // Pop is gated by the live empty flag so a read can never hit an empty FIFO.
    assign bus.fifo_rd_en_o = (state_q == ST_POP) && !bus.fifo_empty_i;
    assign frame_seq_o      = frame_seq_q;
    assign busy_o           = busy_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            req_q       <= 1'b0;
            byte_q      <= 8'd0;
            sample_lo_q <= 8'd0;
            count_q     <= '0;
            frame_seq_q <= 16'd0;
            busy_q      <= 1'b0;
`ifdef FRAMER_CHECKSUM_EN
            cks_q       <= 8'd0;
`endif
        end else begin
            req_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: if (!bus.fifo_empty_i) begin
                    state_q <= ST_SYNC_H;
                    req_q   <= 1'b1;
                    byte_q  <= SYNC_WORD[15:8];
                    busy_q  <= 1'b1;
                end
                ST_SYNC_H: if (byte_done) begin
                    state_q <= ST_SYNC_L;
                    req_q   <= 1'b1;
                    byte_q  <= SYNC_WORD[7:0];
                end
                ST_SYNC_L: if (byte_done) begin
                    state_q <= ST_SEQ_H;
                    req_q   <= 1'b1;
                    byte_q  <= frame_seq_q[15:8];
`ifdef FRAMER_CHECKSUM_EN
                    cks_q   <= frame_seq_q[15:8];
`endif
                end
                ST_SEQ_H: if (byte_done) begin
                    state_q <= ST_SEQ_L;
                    req_q   <= 1'b1;
                    byte_q  <= frame_seq_q[7:0];
`ifdef FRAMER_CHECKSUM_EN
                    cks_q   <= cks_q + frame_seq_q[7:0];
`endif
                end
                ST_SEQ_L: if (byte_done) begin
                    state_q <= ST_POP;
                end
                ST_POP: if (!bus.fifo_empty_i) begin
                    state_q <= ST_LAT;
                end
                ST_LAT: begin
                    state_q     <= ST_SMP_H;
                    req_q       <= 1'b1;
                    byte_q      <= in_bytes.hi;
                    sample_lo_q <= in_bytes.lo;
                    count_q     <= count_q + CNT_W'(1);
`ifdef FRAMER_CHECKSUM_EN
                    cks_q       <= cks_q + in_bytes.hi;
`endif
                end
                ST_SMP_H: if (byte_done) begin
                    state_q <= ST_SMP_L;
                    req_q   <= 1'b1;
                    byte_q  <= sample_lo_q;
`ifdef FRAMER_CHECKSUM_EN
                    cks_q   <= cks_q + sample_lo_q;
`endif
                end
                ST_SMP_L: if (byte_done) begin
                    if (count_q < FRAME_LEN_C) begin
                        state_q <= ST_POP;
                    end else begin
`ifdef FRAMER_CHECKSUM_EN
                        state_q <= ST_CKS;
                        req_q   <= 1'b1;
                        byte_q  <= cks_q;
`else
                        state_q <= ST_END;
`endif
                    end
                end
`ifdef FRAMER_CHECKSUM_EN
                ST_CKS: if (byte_done) begin
                    state_q <= ST_END;
                end
`endif
                ST_END: begin
                    state_q     <= ST_IDLE;
                    frame_seq_q <= frame_seq_q + 16'd1;
                    count_q     <= '0;
                    busy_q      <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    uart_byte_issuer u_issuer (
        .clk       (clk),
        .rst       (rst),
        .req       (req_q),
        .byte_data (byte_q),
        .done      (byte_done),
        .tx_start  (bus.tx_start_o),
        .tx_data   (bus.tx_data_o),
        .tx_done   (bus.tx_done_i)
    );

endmodule
